// File: rtl/uart_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_arb_pkg
// Shared definitions for the UART transmit arbiter:
//   - arb_state_e          : FSM state enum with its fixed 2-bit encoding
//   - ARB_STATE_W          : width of the state encoding
//   - BUSY_TIMEOUT_DEFAULT : default number of cycles allowed for the
//                            transmitter to leave idle after a start pulse
// -----------------------------------------------------------------------------
package uart_arb_pkg;

  localparam int ARB_STATE_W = 2;

  typedef enum logic [ARB_STATE_W-1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_e;

  localparam int BUSY_TIMEOUT_DEFAULT = 8;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational rotate-priority select. Searches the eligible vector
// (i_req & i_mask) starting at i_ptr+1 and wrapping from N-1 to 0, so the
// requester named by i_ptr has the lowest priority.
// Ports:
//   i_req   [N]  : request vector
//   i_mask  [N]  : eligibility mask (1 = may be selected)
//   i_ptr   [IW] : index of the previous winner
//   o_idx   [IW] : selected index (0 when nothing found)
//   o_found      : at least one eligible request exists
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [N-1:0]  i_mask,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  logic [N-1:0] w_elig;

  assign w_elig = i_req & i_mask;

  // Walk offsets from farthest to nearest so the nearest eligible candidate
  // after the pointer is the last one written and therefore wins.
  always_comb begin
    int          cand;
    logic [IW-1:0] cand_idx;
    o_idx    = '0;
    o_found  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int off = N; off >= 1; off--) begin
      cand     = (int'(i_ptr) + off) % N;
      cand_idx = IW'(cand);
      if (w_elig[cand_idx]) begin
        o_found = 1'b1;
        o_idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/uart_xmit_arbiter.sv
// -----------------------------------------------------------------------------
// uart_xmit_arbiter
// Shares one UART transmitter between NUM_REQ byte requesters using
// round-robin arbitration with an optional lock for multi-byte messages.
//
// Handshake: a requester holds req_valid with its byte on req_data; the byte
// is committed when the arbiter samples it at selection, and req_ack pulses
// for exactly one cycle (the ISSUE cycle) to tell the requester it may move
// on. A request withdrawn before selection is simply never acked.
//
// Ports:
//   sys_clk, sys_rst_l   : clock, synchronous active-low reset
//   req_valid [NUM_REQ]  : per-requester byte request
//   req_data  [8*NUM_REQ]: per-requester byte, requester i at [8i+7:8i]
//   req_lock  [NUM_REQ]  : keep the grant for the following byte
//   req_ack   [NUM_REQ]  : one-cycle accept pulse
//   grant_id             : current or last winner
//   tx_xmitH             : start pulse to transmitter
//   tx_dataH  [8]        : byte presented to transmitter
//   tx_doneH             : transmitter idle level (1 = idle)
//   busy                 : FSM not in IDLE
//   err_timeout          : sticky, transmitter never went busy after a start
//   o_dbg_state          : current FSM state
// -----------------------------------------------------------------------------
module uart_xmit_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEFAULT
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_l,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_lock,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       tx_xmitH,
  output logic [7:0]                 tx_dataH,
  input  logic                       tx_doneH,
  output logic                       busy,
  output logic                       err_timeout,
  output arb_state_e                 o_dbg_state
);

  localparam int                   IDW       = $clog2(NUM_REQ);
  localparam int                   TMR_W     = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [NUM_REQ-1:0]   ONE_HOT0  = NUM_REQ'(1);
  localparam logic [IDW-1:0]       LAST_INIT = IDW'(NUM_REQ - 1);
  localparam logic [TMR_W-1:0]     TMR_LAST  = TMR_W'(BUSY_TIMEOUT - 1);

  arb_state_e         r_state;
  arb_state_e         w_next_state;
  logic [IDW-1:0]     r_grant_id;
  logic [IDW-1:0]     r_last_winner;
  logic [IDW-1:0]     r_lock_owner;
  logic               r_lock_vld;
  logic               r_err_timeout;
  logic [7:0]         r_tx_data;
  logic [TMR_W-1:0]   r_timer;

  logic [IDW-1:0]     w_sel_idx;
  logic               w_sel_found;
  logic               w_lock_hold;
  logic [NUM_REQ-1:0] w_mask;
  logic               w_select;
  logic               w_timeout;
  logic [7:0]         w_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign w_bytes[g] = req_data[8*g +: 8];
  end

  // While the owner keeps req_lock high only the owner is eligible, even if
  // it has no byte ready; everyone else waits.
  assign w_lock_hold = r_lock_vld & req_lock[r_lock_owner];
  assign w_mask      = w_lock_hold ? (ONE_HOT0 << r_lock_owner) : '1;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDW)
  ) u_rr_arbiter (
    .i_req   (req_valid),
    .i_mask  (w_mask),
    .i_ptr   (r_last_winner),
    .o_idx   (w_sel_idx),
    .o_found (w_sel_found)
  );

  assign w_select  = (r_state == ST_IDLE) && tx_doneH && w_sel_found;
  // Fires on the BUSY_TIMEOUT-th consecutive idle sample in WAIT_BUSY.
  assign w_timeout = (r_state == ST_WAIT_BUSY) && tx_doneH && (r_timer == TMR_LAST);

  // State register
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_l) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:      if (w_select)  w_next_state = ST_ISSUE;
      ST_ISSUE:                    w_next_state = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (!tx_doneH)      w_next_state = ST_WAIT_DONE;
        else if (w_timeout) w_next_state = ST_IDLE;
      end
      ST_WAIT_DONE: if (tx_doneH)  w_next_state = ST_IDLE;
      default:                     w_next_state = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    tx_xmitH = 1'b0;
    req_ack  = '0;
    busy     = 1'b1;
    case (r_state)
      ST_IDLE:  busy = 1'b0;
      ST_ISSUE: begin
        tx_xmitH = 1'b1;
        req_ack  = ONE_HOT0 << r_grant_id;
      end
      default: ;
    endcase
  end

  // Datapath: grant/data capture, lock, busy timer, round-robin pointer
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_l) begin
      r_grant_id    <= '0;
      r_tx_data     <= '0;
      r_last_winner <= LAST_INIT;
      r_lock_owner  <= '0;
      r_lock_vld    <= 1'b0;
      r_err_timeout <= 1'b0;
      r_timer       <= '0;
    end else begin
      if (w_select) begin
        r_grant_id <= w_sel_idx;
        r_tx_data  <= w_bytes[w_sel_idx];
      end

      // Owner released its lock: drop it now; arbitration this same cycle
      // already sees the full mask because w_lock_hold is low.
      if ((r_state == ST_IDLE) && r_lock_vld && !req_lock[r_lock_owner]) begin
        r_lock_vld <= 1'b0;
      end
      if ((r_state == ST_ISSUE) && req_lock[r_grant_id]) begin
        r_lock_vld   <= 1'b1;
        r_lock_owner <= r_grant_id;
      end
      if (w_timeout) begin
        r_lock_vld    <= 1'b0;
        r_err_timeout <= 1'b1;
      end

      if (r_state == ST_ISSUE) begin
        r_timer <= '0;
      end else if ((r_state == ST_WAIT_BUSY) && tx_doneH) begin
        r_timer <= r_timer + 1'b1;
      end

      if ((r_state == ST_WAIT_DONE) && tx_doneH) begin
        r_last_winner <= r_grant_id;
      end
    end
  end

  assign grant_id    = r_grant_id;
  assign tx_dataH    = r_tx_data;
  assign err_timeout = r_err_timeout;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_xmit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_xmit_arbiter
// Self-checking bench: vector table, hand-written corner sequences, and a
// randomized phase checked against a transaction-level round-robin model.
// -----------------------------------------------------------------------------
module tb_uart_xmit_arbiter;
  import uart_arb_pkg::*;

  localparam int N = 4;
  localparam int T = 8;

  // ---------------- clock / reset / DUT ----------------
  logic           sys_clk   = 1'b0;
  logic           sys_rst_l = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data  = '0;
  logic [N-1:0]   req_lock  = '0;
  logic [N-1:0]   req_ack;
  logic [1:0]     grant_id;
  logic           tx_xmitH;
  logic [7:0]     tx_dataH;
  logic           tx_doneH  = 1'b1;
  logic           busy;
  logic           err_timeout;
  arb_state_e     dbg_state;

  always #5 sys_clk = ~sys_clk;

  uart_xmit_arbiter #(
    .NUM_REQ      (N),
    .BUSY_TIMEOUT (T)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_l   (sys_rst_l),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_lock    (req_lock),
    .req_ack     (req_ack),
    .grant_id    (grant_id),
    .tx_xmitH    (tx_xmitH),
    .tx_dataH    (tx_dataH),
    .tx_doneH    (tx_doneH),
    .busy        (busy),
    .err_timeout (err_timeout),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [9:0] exp_q[$];   // {grant id, byte}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    sys_rst_l = 1'b0;
    req_valid = '0;
    req_lock  = '0;
    req_data  = '0;
    tx_doneH  = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_l = 1'b1;
  endtask

  // Present a request set, wait (bounded) for the start pulse, capture the
  // ISSUE-cycle outputs, then emulate the transmitter: stay idle for `hold`
  // more cycles, go busy for `lo` cycles, return idle.
  task automatic xfer(input logic [N-1:0] v, input logic [N-1:0] lk,
                      input logic [8*N-1:0] d, input int hold, input int lo,
                      output int waited, output bit seen, output logic [1:0] id,
                      output logic [N-1:0] ack, output logic [7:0] dat);
    req_valid = v;
    req_lock  = lk;
    req_data  = d;
    waited    = 0;
    seen      = 1'b0;
    while (!seen && waited < 40) begin
      @(negedge sys_clk);
      waited++;
      if (tx_xmitH === 1'b1) seen = 1'b1;
    end
    id  = grant_id;
    ack = req_ack;
    dat = tx_dataH;
    if (seen) begin
      @(posedge sys_clk);
      #1;
      repeat (hold) @(posedge sys_clk);
      #1 tx_doneH = 1'b0;
      repeat (lo) @(posedge sys_clk);
      #1 tx_doneH = 1'b1;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0]   v;
    logic [N-1:0]   lk;
    logic [8*N-1:0] d;
    int             exp_id;
  } vec_t;

  vec_t tbl[13];

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int             waited;
    bit             seen;
    logic [1:0]     id;
    logic [N-1:0]   ack;
    logic [7:0]     dat;
    logic [8*N-1:0] dd;
    int             xm;
    int             m_last;
    bit             m_lock_vld;
    int             m_owner;
    int             e;
    bit             found;
    logic [N-1:0]   v;
    logic [N-1:0]   lk;
    logic [8*N-1:0] d;
    logic [9:0]     ex;
    logic [1:0]     eid;

    tbl[0]  = '{4'b1111, 4'b0000, 32'h13121110, 0};
    tbl[1]  = '{4'b1111, 4'b0000, 32'h23222120, 1};
    tbl[2]  = '{4'b1111, 4'b0000, 32'h33323130, 2};
    tbl[3]  = '{4'b1111, 4'b0000, 32'h43424140, 3};
    tbl[4]  = '{4'b1111, 4'b0000, 32'h53525150, 0};
    tbl[5]  = '{4'b0101, 4'b0100, 32'h00AA0061, 2};
    tbl[6]  = '{4'b0101, 4'b0100, 32'h00550062, 2};
    tbl[7]  = '{4'b0101, 4'b0100, 32'h00FF0063, 2};
    tbl[8]  = '{4'b0101, 4'b0000, 32'h00EE0064, 0};
    tbl[9]  = '{4'b0110, 4'b0000, 32'h00757400, 1};
    tbl[10] = '{4'b1001, 4'b0000, 32'h86000085, 3};
    tbl[11] = '{4'b1000, 4'b0000, 32'h97000000, 3};
    tbl[12] = '{4'b0001, 4'b0001, 32'h000000A8, 0};

    // ---- reset values ----
    do_reset();
    @(negedge sys_clk);
    check("rst_xmit",  tx_xmitH,    0);
    check("rst_ack",   req_ack,     0);
    check("rst_busy",  busy,        0);
    check("rst_data",  tx_dataH,    0);
    check("rst_grant", grant_id,    0);
    check("rst_err",   err_timeout, 0);

    // ---- table: round-robin order, lock for 3 bytes, wrap ----
    for (int i = 0; i < 13; i++) begin
      xfer(tbl[i].v, tbl[i].lk, tbl[i].d, 0, 2, waited, seen, id, ack, dat);
      dd = tbl[i].d;
      check($sformatf("tbl%0d_seen", i), seen, 1);
      check($sformatf("tbl%0d_id", i),   id,   tbl[i].exp_id);
      check($sformatf("tbl%0d_ack", i),  ack,  4'b0001 << tbl[i].exp_id);
      check($sformatf("tbl%0d_data", i), dat,  dd[8*tbl[i].exp_id +: 8]);
    end

    // ---- lock owner 0 absent but still locking: requester 1 must wait ----
    req_valid = 4'b0010;
    req_lock  = 4'b0001;
    req_data  = 32'h00003C00;
    xm = 0;
    repeat (10) begin
      @(negedge sys_clk);
      if (tx_xmitH) xm++;
    end
    check("lock_wait_no_xmit", xm, 0);
    xfer(4'b0010, 4'b0000, 32'h00003C00, 0, 2, waited, seen, id, ack, dat);
    check("lock_release_seen", seen, 1);
    check("lock_release_id",   id,   1);
    check("lock_release_data", dat,  8'h3C);

    // ---- one-cycle latency, then busy timeout with tx_doneH stuck high ----
    do_reset();
    @(negedge sys_clk);
    req_valid = 4'b0010;
    req_data  = 32'h00005A00;
    @(negedge sys_clk);
    check("lat_xmit",  tx_xmitH, 1);
    check("lat_ack",   req_ack,  4'b0010);
    check("lat_grant", grant_id, 1);
    check("lat_data",  tx_dataH, 8'h5A);
    req_valid = '0;
    @(negedge sys_clk);
    check("lat_xmit_once", tx_xmitH, 0);
    check("lat_ack_once",  req_ack,  0);
    check("wb_busy",       busy,     1);
    for (int k = 1; k <= T; k++) begin
      @(negedge sys_clk);
      check($sformatf("to_err_k%0d", k),  err_timeout, (k == T) ? 1 : 0);
      check($sformatf("to_busy_k%0d", k), busy,        (k == T) ? 0 : 1);
    end
    repeat (3) @(negedge sys_clk);
    check("to_err_sticky", err_timeout, 1);
    check("to_idle",       busy,        0);

    // ---- reset during WAIT_DONE ----
    do_reset();
    xfer(4'b0010, 4'b0000, 32'h00002100, 0, 2, waited, seen, id, ack, dat);
    check("rwd_first_id", id, 1);
    req_valid = 4'b0100;
    req_data  = 32'h00C30000;
    waited = 0;
    seen   = 1'b0;
    while (!seen && waited < 40) begin
      @(negedge sys_clk);
      waited++;
      if (tx_xmitH === 1'b1) seen = 1'b1;
    end
    check("rwd_second_seen", seen,     1);
    check("rwd_second_id",   grant_id, 2);
    check("rwd_second_data", tx_dataH, 8'hC3);
    @(posedge sys_clk);
    #1 tx_doneH = 1'b0;
    req_valid = '0;
    @(posedge sys_clk);
    #1;
    @(negedge sys_clk);
    check("rwd_in_wait_done", dbg_state, ST_WAIT_DONE);
    sys_rst_l = 1'b0;
    @(negedge sys_clk);
    check("rwd_state", dbg_state,   ST_IDLE);
    check("rwd_busy",  busy,        0);
    check("rwd_xmit",  tx_xmitH,    0);
    check("rwd_ack",   req_ack,     0);
    check("rwd_grant", grant_id,    0);
    check("rwd_data",  tx_dataH,    0);
    check("rwd_err",   err_timeout, 0);
    sys_rst_l = 1'b1;
    tx_doneH  = 1'b1;
    @(negedge sys_clk);
    check("rwd_no_ack", req_ack, 0);
    xfer(4'b1111, 4'b0000, 32'h44332211, 0, 2, waited, seen, id, ack, dat);
    check("rwd_next_id",   id,  0);
    check("rwd_next_data", dat, 8'h11);

    // ---- randomized traffic against a transaction-level model ----
    do_reset();
    m_last     = N - 1;
    m_lock_vld = 1'b0;
    m_owner    = 0;
    exp_q.delete();
    for (int r = 0; r < 200; r++) begin
      v = 4'($urandom_range(1, 15));
      for (int b = 0; b < N; b++) lk[b] = ($urandom_range(0, 3) == 0);
      if (m_lock_vld && lk[m_owner]) v[m_owner] = 1'b1;
      d = $urandom;

      e = 0;
      if (m_lock_vld && lk[m_owner]) begin
        e = m_owner;
      end else begin
        m_lock_vld = 1'b0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          if (!found && v[(m_last + k) % N]) begin
            e = (m_last + k) % N;
            found = 1'b1;
          end
        end
      end
      eid = 2'(e);
      exp_q.push_back({eid, d[8*e +: 8]});

      xfer(v, lk, d, $urandom_range(0, T - 1), $urandom_range(1, 4),
           waited, seen, id, ack, dat);
      check($sformatf("rnd%0d_seen", r), seen, 1);
      if (r > 0 && seen) check($sformatf("rnd%0d_latency", r), waited, 3);
      ex = exp_q.pop_front();
      check($sformatf("rnd%0d_id", r),   id,  ex[9:8]);
      check($sformatf("rnd%0d_ack", r),  ack, 4'b0001 << ex[9:8]);
      check($sformatf("rnd%0d_data", r), dat, ex[7:0]);

      if (lk[e]) begin
        m_lock_vld = 1'b1;
        m_owner    = e;
      end
      m_last = e;
    end
    @(negedge sys_clk);
    check("rnd_no_timeout", err_timeout, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_xmit_arbiter.md
UART_XMIT_ARBITER -- requirements
Module: uart_xmit_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, is the number of requesters; legal values are 2..8.
REQ-002 Parameter BUSY_TIMEOUT, default 8, is the number of cycles allowed for tx_doneH to fall after a start pulse.
REQ-003 sys_clk  in  1  is the single clock; all logic is rising-edge.
REQ-004 sys_rst_l  in  1  is the reset; it SHALL be synchronous and active-low.
REQ-005 req_valid  in  NUM_REQ  carries one byte request per requester.
REQ-006 req_data  in  8*NUM_REQ  is the request byte; requester i uses bits [8i+7:8i].
REQ-007 req_lock  in  NUM_REQ  asks to keep the grant for the next byte (multi-byte message).
REQ-008 req_ack  out  NUM_REQ  is a one-cycle pulse marking that the byte was accepted.
REQ-009 grant_id  out  clog2(NUM_REQ)  is the index of the current or last winner.
REQ-010 tx_xmitH  out  1  is the start pulse to the UART transmitter.
REQ-011 tx_dataH  out  8  is the byte presented to the transmitter.
REQ-012 tx_doneH  in  1  is the transmitter idle level (high = idle).
REQ-013 busy  out  1  is high whenever the state is not IDLE.
REQ-014 err_timeout  out  1  is a sticky flag: the transmitter never went busy.

Function
REQ-015 The FSM SHALL have four states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-016 IDLE: when tx_doneH=1 and any req_valid=1, the block SHALL pick a winner, register its index into grant_id and its data into tx_dataH, and go to ISSUE.
REQ-017 IDLE with tx_doneH=0 SHALL not arbitrate; all requests wait.
REQ-018 Arbitration SHALL be round-robin: search from last_winner+1 upward, wrapping at NUM_REQ-1 to 0.
REQ-019 Lock: if lock_owner is set and req_lock[owner]=1, only the owner SHALL be eligible; other requests wait, even if the owner's req_valid=0.
REQ-020 The lock SHALL be cleared when req_lock[owner]=0 is sampled in IDLE; normal round-robin then applies in that same cycle.
REQ-021 ISSUE lasts exactly one cycle: tx_xmitH=1 and req_ack[grant_id]=1 in that cycle; lock_owner is set to grant_id if req_lock[grant_id]=1 then; next state is WAIT_BUSY.
REQ-022 Latency: req_valid sampled at edge N produces tx_xmitH and req_ack high during cycle N..N+1 (one cycle after selection).
REQ-023 tx_dataH and grant_id SHALL hold steady from selection until the next selection.
REQ-024 WAIT_BUSY: tx_doneH=0 SHALL go to WAIT_DONE.
REQ-025 WAIT_BUSY timeout: after BUSY_TIMEOUT cycles with tx_doneH=1, err_timeout is set, lock_owner is cleared, and the FSM returns to IDLE.
REQ-026 WAIT_DONE: tx_doneH=1 SHALL update last_winner to grant_id and return to IDLE; there is no timeout in this state.
REQ-027 Back-to-back: the earliest next tx_xmitH is 2 cycles after tx_doneH rises (one WAIT_DONE exit cycle plus one IDLE selection cycle).
REQ-028 A req_valid dropped before selection SHALL not be acked; a request sampled at selection is committed.
REQ-029 Exactly one req_ack bit may be high per cycle, and only in ISSUE.

Reset
REQ-030 On sys_rst_l=0 at a clock edge:
- state = IDLE
- tx_xmitH = 0, req_ack = 0, busy = 0
- tx_dataH = 0, grant_id = 0
- err_timeout = 0, lock_owner cleared
- last_winner = NUM_REQ-1, so requester 0 wins first.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer at that edge with no further req_ack or tx_xmitH.

Structure
REQ-032 Shared package uart_arb_pkg SHALL hold the state enum, the state encoding, and the BUSY_TIMEOUT default constant.
REQ-033 One sub-module rr_arbiter SHALL be used: combinational rotate-priority select over a request vector with pointer and mask inputs, returning index and found.

Verification
REQ-034 After reset, req_valid=4'b1111, tx_doneH emulated -> acks in order 0,1,2,3,0 with tx_dataH matching each request byte.
REQ-035 req_valid[2] with lock held for 3 bytes (AA,55,FF) while req_valid[0]=1 -> requester 2 gets 3 consecutive acks, then requester 0 is acked.
REQ-036 tx_doneH held at 1 after a start pulse -> err_timeout=1 exactly BUSY_TIMEOUT cycles after WAIT_BUSY entry, busy=0 the next cycle.
REQ-037 req_valid[1] at edge N with IDLE and tx_doneH=1 -> tx_xmitH=1 and req_ack=4'b0010 in cycle N+1 only.
REQ-038 sys_rst_l=0 during WAIT_DONE -> next cycle IDLE, all outputs at reset values, and the next winner is requester 0.
